// File: rtl/lsu_pkg.sv
// lsu_pkg: LSU state encoding, RV32I load/store funct3 widths and access legality.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Legal width for the direction, and naturally aligned for that width.
  function automatic logic access_ok(input logic load, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = load;
      F3_HU:   ok = load & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_wb_load_extend.sv
// load_extend: lane-select a loaded word by byte offset and sign/zero-extend per funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ext = {24'h000000, shifted[7:0]};
      F3_HU:   ext = {16'h0000, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// lsu_wb: multi-cycle RV32I load/store unit with req/gnt/rvalid memory handshake and
// register-file writeback. Define LSU_TIMEOUT_EN to enable the REQ/WAIT watchdog.
module lsu_wb
  import lsu_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        err,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, nxt;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        legal, accept, reject, timeout;
  logic [3:0]  strb;
  logic [31:0] wdat, ext;

  assign legal = access_ok(req_load, funct3, addr[1:0]);
  // err high in IDLE marks the instruction already rejected: release it, don't re-check.
  assign accept = (state == IDLE) && req_valid && !err && legal;
  assign reject = (state == IDLE) && req_valid && !err && !legal;

`ifdef LSU_TIMEOUT_EN
  logic [31:0] tcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             tcnt <= '0;
    else if (accept)                      tcnt <= '0;
    else if (state == REQ || state == WAIT) tcnt <= tcnt + 32'd1;
  end

  assign timeout = (state == REQ || state == WAIT) && (tcnt == TIMEOUT_CYCLES - 32'd1);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    case (funct3)
      F3_B:    begin strb = 4'b0001 << addr[1:0]; wdat = {4{store_data[7:0]}};  end
      F3_H:    begin strb = 4'b0011 << addr[1:0]; wdat = {2{store_data[15:0]}}; end
      default: begin strb = 4'b1111;              wdat = store_data;            end
    endcase
  end

  load_extend u_ext (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .ext    (ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt   = state;
    stall = 1'b0;
    case (state)
      IDLE: begin
        stall = req_valid & ~err;
        if (accept) nxt = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (mem_gnt)      nxt = ld_q ? WAIT : DONE;
        else if (timeout) nxt = DONE;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rvalid || timeout) nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
      ld_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= ~req_load;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wstrb <= req_load ? 4'b0000 : strb;
            mem_wdata <= req_load ? 32'h0 : wdat;
            ld_q      <= req_load;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            rd_q      <= rd;
          end else if (reject) begin
            err <= 1'b1;
          end
        end
        REQ: begin
          if (mem_gnt || timeout) mem_req <= 1'b0;
          if (!mem_gnt && timeout) err <= 1'b1;
        end
        WAIT: begin
          if (mem_rvalid) begin
            wb_data <= ext;
            wb_addr <= rd_q;
            wb_we   <= (rd_q != 5'd0);
          end else if (timeout) begin
            err <= 1'b1;
          end
        end
        DONE:    wb_we <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
